// File: rtl/io_port_unit.sv
// Memory-mapped I/O responder: synchronised input port, output port, sticky rising-edge flags, prescaled timer.
// Optional interrupt output is built when the IO_IRQ_EN macro is defined.
module io_port_unit #(
  parameter int DATA_W   = 16,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iom_in,
  input  logic              wen_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] port_in,
`ifdef IO_IRQ_EN
  input  logic [DATA_W-1:0] irq_mask_in,
  output logic              irq_out,
`endif
  output logic [DATA_W-1:0] port_out
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [DATA_W-1:0]  DATA_ZERO  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]  DATA_ONE   = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ADDR_IN    = 2'd0;
  localparam logic [1:0] ADDR_OUT   = 2'd1;
  localparam logic [1:0] ADDR_FLAGS = 2'd2;
  localparam logic [1:0] ADDR_TIMER = 2'd3;

  logic [DATA_W-1:0]  s1_r, s2_r, s3_r;
  logic [DATA_W-1:0]  out_r, flags_r, timer_r;
  logic [PRESC_W-1:0] presc_r;

  logic               wr_s;
  logic               tick_s;
  logic [DATA_W-1:0]  rise_s;
  logic [DATA_W-1:0]  out_nxt_s, flags_nxt_s, timer_nxt_s;
  logic [PRESC_W-1:0] presc_nxt_s;

  assign wr_s     = iom_in & ~wen_in;
  assign tick_s   = (presc_r == PRESC_LAST);
  assign rise_s   = s2_r & ~s3_r;
  assign port_out = out_r;

  // Next-state for the writable registers; a new rising edge always beats a clear on the same bit.
  always_comb begin
    out_nxt_s   = out_r;
    flags_nxt_s = flags_r | rise_s;
    timer_nxt_s = timer_r;
    presc_nxt_s = presc_r + PRESC_ONE;
    if (tick_s) begin
      presc_nxt_s = {PRESC_W{1'b0}};
      timer_nxt_s = timer_r + DATA_ONE;
    end else begin
      presc_nxt_s = presc_r + PRESC_ONE;
    end
    if (wr_s) begin
      case (addr_in[1:0])
        ADDR_OUT:   out_nxt_s = data_in;
        ADDR_FLAGS: flags_nxt_s = (flags_r & ~data_in) | rise_s;
        ADDR_TIMER: begin
          // A timer write drops any tick landing in the same cycle.
          timer_nxt_s = data_in;
          presc_nxt_s = {PRESC_W{1'b0}};
        end
        default:    out_nxt_s = out_r;
      endcase
    end else begin
      out_nxt_s = out_r;
    end
  end

  // Same-cycle read mux; quiet whenever no read cycle is in progress.
  always_comb begin
    data_out = DATA_ZERO;
    if (!rst_n || !iom_in || !wen_in) begin
      data_out = DATA_ZERO;
    end else begin
      case (addr_in[1:0])
        ADDR_IN:    data_out = s2_r;
        ADDR_OUT:   data_out = out_r;
        ADDR_FLAGS: data_out = flags_r;
        ADDR_TIMER: data_out = timer_r;
        default:    data_out = DATA_ZERO;
      endcase
    end
  end

  // Input synchroniser, edge-history flop and register state; reset discards any pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r    <= DATA_ZERO;
      s2_r    <= DATA_ZERO;
      s3_r    <= DATA_ZERO;
      out_r   <= DATA_ZERO;
      flags_r <= DATA_ZERO;
      timer_r <= DATA_ZERO;
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      s1_r    <= port_in;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      out_r   <= out_nxt_s;
      flags_r <= flags_nxt_s;
      timer_r <= timer_nxt_s;
      presc_r <= presc_nxt_s;
    end
  end

`ifdef IO_IRQ_EN
  // Interrupt request follows the masked flags one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_out <= 1'b0;
    end else begin
      irq_out <= |(flags_r & irq_mask_in);
    end
  end
`endif

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: expected read data is queued when a read is driven and compared when data_out settles.
module tb_io_port_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iom_in;
  logic          wen_in;
  logic [W-1:0]  addr_in;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic [W-1:0]  port_in;
  logic [W-1:0]  port_out;
`ifdef IO_IRQ_EN
  logic [W-1:0]  irq_mask_in;
  logic          irq_out;
`endif

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_chk  = 0;
  int       n_pass = 0;

  io_port_unit #(.DATA_W(W), .PRESCALE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iom_in      (iom_in),
    .wen_in      (wen_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .port_in     (port_in),
`ifdef IO_IRQ_EN
    .irq_mask_in (irq_mask_in),
    .irq_out     (irq_out),
`endif
    .port_out    (port_out)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives one I/O write across a single rising edge, returning at the following falling edge.
  task automatic io_write(input logic [W-1:0] a, input logic [W-1:0] d);
    iom_in = 1'b1; wen_in = 1'b0; addr_in = a; data_in = d;
    @(negedge clk);
    iom_in = 1'b0; wen_in = 1'b1;
  endtask

  // Drives a read between edges, queues the expectation, then pops and compares once data_out settles.
  task automatic io_read(input string tag, input logic [W-1:0] a, input logic [W-1:0] exp);
    sb_item_t it;
    it.tag = tag; it.val = exp;
    sb_q.push_back(it);
    iom_in = 1'b1; wen_in = 1'b1; addr_in = a;
    #1;
    it = sb_q.pop_front();
    check_eq(it.tag, data_out, it.val);
    iom_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; iom_in = 1'b0; wen_in = 1'b1;
    addr_in = 16'h0000; data_in = 16'h0000; port_in = 16'hFFFF;
`ifdef IO_IRQ_EN
    irq_mask_in = 16'h0010;
`endif
    cyc(2);
    check_eq("rst_port_out", port_out, 16'h0000);
    io_read("rst_rd_in", 16'h0000, 16'h0000);
    port_in = 16'h0000;
    rst_n   = 1'b1;
    io_read("rst_flags", 16'h0002, 16'h0000);
    io_read("rst_in", 16'h0000, 16'h0000);

    io_write(16'h0001, 16'hA5C3);
    check_eq("out_port", port_out, 16'hA5C3);
    io_read("out_rd", 16'h0001, 16'hA5C3);
    io_read("out_alias", 16'h0005, 16'hA5C3);

    port_in = 16'h0011;
    cyc(1);
    io_read("sync_lat1", 16'h0000, 16'h0000);
    cyc(1);
    io_read("sync_lat2", 16'h0000, 16'h0011);
    io_read("flag_lat2", 16'h0002, 16'h0000);
    cyc(1);
    io_read("flag_lat3", 16'h0002, 16'h0011);
    io_write(16'h0002, 16'h0001);
    io_read("flag_w1c", 16'h0002, 16'h0010);

    io_write(16'h0000, 16'hFFFF);
    io_read("in_ro", 16'h0000, 16'h0011);
    check_eq("in_wr_out", port_out, 16'hA5C3);

    port_in = 16'h0000;
    cyc(3);
    io_read("flag_fall", 16'h0002, 16'h0010);
    io_write(16'h0002, 16'h0010);
    io_read("flag_clr4", 16'h0002, 16'h0000);
    port_in = 16'h0010;
    cyc(2);
    io_write(16'h0002, 16'h0010);
    io_read("flag_collide", 16'h0002, 16'h0010);

    iom_in = 1'b0; wen_in = 1'b0; addr_in = 16'h0002; data_in = 16'hFFFF;
    #1;
    check_eq("idle_dout", data_out, 16'h0000);
    cyc(1);
    addr_in = 16'h0001;
    cyc(1);
    wen_in = 1'b1;
    io_read("idle_flags", 16'h0002, 16'h0010);
    io_read("idle_out", 16'h0001, 16'hA5C3);
    check_eq("idle_port", port_out, 16'hA5C3);
    io_write(16'h0002, 16'h0010);
    io_read("flag_clr_ok", 16'h0002, 16'h0000);

`ifdef IO_IRQ_EN
    port_in = 16'h0000;
    cyc(3);
    check_eq("irq_idle", {15'd0, irq_out}, 16'h0000);
    port_in = 16'h0010;
    cyc(3);
    io_read("irq_flag", 16'h0002, 16'h0010);
    check_eq("irq_lag", {15'd0, irq_out}, 16'h0000);
    cyc(1);
    check_eq("irq_set", {15'd0, irq_out}, 16'h0001);
`endif

    io_write(16'h0003, 16'hFFFE);
    io_read("tmr_wr", 16'h0003, 16'hFFFE);
    cyc(3);
    io_read("tmr_3", 16'h0003, 16'hFFFE);
    cyc(1);
    io_read("tmr_4", 16'h0003, 16'hFFFF);
    cyc(4);
    io_read("tmr_wrap", 16'h0003, 16'h0000);
    cyc(3);
    io_write(16'h0003, 16'h1234);
    io_read("tmr_tick_wr", 16'h0003, 16'h1234);
    cyc(3);
    io_read("tmr_presc_clr", 16'h0003, 16'h1234);
    cyc(1);
    io_read("tmr_next", 16'h0003, 16'h1235);

    iom_in = 1'b1; wen_in = 1'b0; addr_in = 16'h0001; data_in = 16'h1234;
    rst_n = 1'b0;
    cyc(1);
    iom_in = 1'b0; wen_in = 1'b1;
    check_eq("rst_abort", port_out, 16'h0000);
    rst_n = 1'b1;
    io_read("rst_abort_rd", 16'h0001, 16'h0000);
    io_read("rst_tmr", 16'h0003, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
